// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and constants for the I2C register target.
// Configuration macro: I2C_TARGET_WHOAMI_EN (see i2c_target_regs).
package i2c_pkg;
   localparam int         NUM_REGS   = 16;
   localparam logic [7:0] WHOAMI_PTR = 8'h75;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RACK
   } i2c_state_t;
endpackage

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronises SCL/SDA and flags SCL edges and START/STOP.
// All flops reset to 1 (idle bus) so no edge or condition fires out of reset.
module i2c_bus_monitor (
   input  logic clk,
   input  logic reset_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);
   logic scl_m, scl_s, scl_d;
   logic sda_m, sda_d;

   // Two-flop synchronisers plus one history flop per line for edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         {scl_m, scl_s, scl_d} <= 3'b111;
         {sda_m, sda_s, sda_d} <= 3'b111;
      end else begin
         scl_m <= scl_in;
         scl_s <= scl_m;
         scl_d <= scl_s;
         sda_m <= sda_in;
         sda_s <= sda_m;
         sda_d <= sda_s;
      end
   end

   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   // SDA moving while SCL is held high is a bus condition, never data
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with an 8-bit auto-incrementing pointer into a
// 16 x 8 register file, plus a fabric-side write/read port.
// Optional macro I2C_TARGET_WHOAMI_EN: pointer 0x75 reads DEVICE_ADDRESS and
// drops writes instead of aliasing register 5.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [7:0] DEVICE_ADDRESS = 8'h68
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic       loc_we,
   input  logic [3:0] loc_addr,
   input  logic [7:0] loc_wdata,
   output logic [7:0] loc_rdata,
   output logic       host_wr,
   output logic [3:0] host_addr,
   output logic [7:0] host_data,
   output logic       busy
);
   i2c_state_t state;
   logic [7:0] regs [NUM_REGS];
   logic [7:0] ptr;
   logic [7:0] rx;
   logic [7:0] tx;
   logic [3:0] bit_cnt;
   logic       rack_nack;
   logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic       whoami_hit;
   logic [7:0] rd_byte;

   i2c_bus_monitor u_mon (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

`ifdef I2C_TARGET_WHOAMI_EN
   assign whoami_hit = (ptr == WHOAMI_PTR);
`else
   assign whoami_hit = 1'b0;
`endif

   assign rd_byte   = whoami_hit ? DEVICE_ADDRESS : regs[ptr[3:0]];
   assign loc_rdata = regs[loc_addr];

   // Protocol FSM and register file; SDA only changes on synced SCL falls
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         sda_out   <= 1'b1;
         ptr       <= '0;
         rx        <= '0;
         tx        <= '0;
         bit_cnt   <= '0;
         rack_nack <= 1'b0;
         busy      <= 1'b0;
         host_wr   <= 1'b0;
         host_addr <= '0;
         host_data <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         host_wr <= 1'b0;
         if (stop_det) begin
            state   <= IDLE;
            sda_out <= 1'b1;
            busy    <= 1'b0;
         end else if (start_det) begin
            // Repeated START keeps ptr so a pointer write can precede a read
            state   <= ADDR;
            sda_out <= 1'b1;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: ;
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     rx      <= {rx[6:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     bit_cnt <= '0;
                     if (state == ADDR) begin
                        if (rx[7:1] == DEVICE_ADDRESS[6:0]) begin
                           sda_out <= 1'b0;
                           busy    <= 1'b1;
                           state   <= ADDR_ACK;
                        end else begin
                           busy  <= 1'b0;
                           state <= IDLE;
                        end
                     end else if (state == PTR) begin
                        ptr     <= rx;
                        sda_out <= 1'b0;
                        state   <= PTR_ACK;
                     end else begin
                        sda_out <= 1'b0;
                        state   <= WDATA_ACK;
                        ptr     <= ptr + 8'd1;
                        if (!whoami_hit) begin
                           regs[ptr[3:0]] <= rx;
                           host_wr        <= 1'b1;
                           host_addr      <= ptr[3:0];
                           host_data      <= rx;
                        end
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall) begin
                     if (rx[0]) begin
                        tx      <= rd_byte;
                        sda_out <= rd_byte[7];
                        state   <= RDATA;
                     end else begin
                        sda_out <= 1'b1;
                        state   <= PTR;
                     end
                  end
               end
               PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     sda_out <= 1'b1;
                     state   <= WDATA;
                  end
               end
               RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_out <= 1'b1;
                        ptr     <= ptr + 8'd1;
                        bit_cnt <= '0;
                        state   <= RACK;
                     end else begin
                        tx      <= {tx[6:0], 1'b0};
                        sda_out <= tx[6];
                     end
                  end
               end
               RACK: begin
                  if (scl_rise) begin
                     rack_nack <= sda_s;
                  end else if (scl_fall) begin
                     if (rack_nack) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        tx      <= rd_byte;
                        sda_out <= rd_byte[7];
                        state   <= RDATA;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
         // Fabric write lands last so it wins a same-cycle collision
         if (loc_we) regs[loc_addr] <= loc_wdata;
      end
   end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bus transactions against i2c_target_regs.
module tb_i2c_target_regs;
   import i2c_pkg::*;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_host = 1'b1;
   logic       sda_in;
   logic       sda_out;
   logic       loc_we = 1'b0;
   logic [3:0] loc_addr = 4'd0;
   logic [7:0] loc_wdata = 8'd0;
   logic [7:0] loc_rdata;
   logic       host_wr;
   logic [3:0] host_addr;
   logic [7:0] host_data;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int         hw_cnt = 0;
   int         hw_wide = 0;
   logic       hw_prev = 1'b0;
   logic [3:0] hw_addr = 4'd0;
   logic [7:0] hw_data = 8'd0;
   int         lo_cnt = 0;

   always #5 clk = ~clk;

   // wired-AND open-drain bus
   assign sda_in = sda_host & sda_out;

   i2c_target_regs dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .scl_in    (scl),
      .sda_in    (sda_in),
      .sda_out   (sda_out),
      .loc_we    (loc_we),
      .loc_addr  (loc_addr),
      .loc_wdata (loc_wdata),
      .loc_rdata (loc_rdata),
      .host_wr   (host_wr),
      .host_addr (host_addr),
      .host_data (host_data),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (host_wr === 1'b1) begin
         hw_cnt++;
         hw_addr = host_addr;
         hw_data = host_data;
         if (hw_prev) hw_wide++;
      end
      hw_prev = host_wr;
      if (sda_out === 1'b0) lo_cnt++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic rd_reg(input logic [3:0] idx, output logic [7:0] d);
      loc_addr = idx;
      #1;
      d = loc_rdata;
   endtask

   task automatic loc_write(input logic [3:0] idx, input logic [7:0] d);
      loc_we = 1'b1; loc_addr = idx; loc_wdata = d;
      tick(1);
      loc_we = 1'b0;
   endtask

   task automatic bus_start();
      sda_host = 1'b1; tick(Q);
      scl = 1'b1;      tick(Q);
      sda_host = 1'b0; tick(Q);
      scl = 1'b0;      tick(Q);
   endtask

   task automatic bus_stop();
      sda_host = 1'b0; tick(Q);
      scl = 1'b1;      tick(Q);
      sda_host = 1'b1; tick(Q);
   endtask

   task automatic clk_bit(input logic b, output logic seen);
      sda_host = b; tick(Q);
      scl = 1'b1;   tick(Q / 2);
      seen = sda_in;
      tick(Q / 2);
      scl = 1'b0;   tick(Q);
   endtask

   // returns the sampled 9th bit: 0 = ACK
   task automatic write_byte(input logic [7:0] b, output logic ackb);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, ackb);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
      clk_bit(nack, s);
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [7:0] ptr;
      logic [7:0] data;
      logic       ackb;
      logic [3:0] idx;
      logic [7:0] exp;
      int         hw;
   } vec_t;

   initial begin
      vec_t       tbl [5];
      logic       a;
      logic [7:0] d;
      int         hw0, lo0;

      tbl[0] = '{8'hD0, 8'h01, 8'h5A, 1'b0, 4'd1,  8'h5A, 1};
      tbl[1] = '{8'hD0, 8'h0E, 8'hC3, 1'b0, 4'd14, 8'hC3, 1};
      tbl[2] = '{8'hA0, 8'h02, 8'hFF, 1'b1, 4'd2,  8'h00, 0};
      tbl[3] = '{8'hD0, 8'h28, 8'h81, 1'b0, 4'd8,  8'h81, 1};
      tbl[4] = '{8'hD2, 8'h09, 8'h44, 1'b1, 4'd9,  8'h00, 0};

      // reset
      tick(3);
      reset_n = 1'b1;
      tick(2);
      chk("rst_sda_out", 32'(sda_out), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_host_wr", 32'(host_wr), 32'd0);
      chk("rst_state", 32'(dut.state), 32'(IDLE));
      rd_reg(4'd0, d);  chk("rst_reg0", 32'(d), 32'h00);
      rd_reg(4'd15, d); chk("rst_reg15", 32'(d), 32'h00);

      // table: one single-byte write transaction per entry
      for (int i = 0; i < 5; i++) begin
         hw0 = hw_cnt;
         bus_start();
         write_byte(tbl[i].addr, a); chk($sformatf("tbl%0d_addr_ack", i), 32'(a), 32'(tbl[i].ackb));
         write_byte(tbl[i].ptr, a);  chk($sformatf("tbl%0d_ptr_ack", i), 32'(a), 32'(tbl[i].ackb));
         write_byte(tbl[i].data, a); chk($sformatf("tbl%0d_data_ack", i), 32'(a), 32'(tbl[i].ackb));
         bus_stop();
         rd_reg(tbl[i].idx, d);
         chk($sformatf("tbl%0d_reg", i), 32'(d), 32'(tbl[i].exp));
         chk($sformatf("tbl%0d_hw", i), 32'(hw_cnt - hw0), 32'(tbl[i].hw));
      end

      // two-byte write with auto-increment
      hw0 = hw_cnt;
      bus_start();
      write_byte(8'hD0, a); chk("w2_addr_ack", 32'(a), 32'd0);
      chk("w2_busy", 32'(busy), 32'd1);
      write_byte(8'h03, a); chk("w2_ptr_ack", 32'(a), 32'd0);
      write_byte(8'hAA, a); chk("w2_d0_ack", 32'(a), 32'd0);
      write_byte(8'h55, a); chk("w2_d1_ack", 32'(a), 32'd0);
      bus_stop();
      rd_reg(4'd3, d); chk("w2_reg3", 32'(d), 32'hAA);
      rd_reg(4'd4, d); chk("w2_reg4", 32'(d), 32'h55);
      chk("w2_hw_pulses", 32'(hw_cnt - hw0), 32'd2);
      chk("w2_hw_last", {20'd0, hw_addr, hw_data}, {20'd0, 4'd4, 8'h55});
      chk("w2_busy_after_stop", 32'(busy), 32'd0);

      // pointer write, repeated START, read with ACK then NACK
      loc_write(4'd2, 8'h3C);
      rd_reg(4'd2, d); chk("loc_reg2", 32'(d), 32'h3C);
      bus_start();
      write_byte(8'hD0, a); chk("rd_waddr_ack", 32'(a), 32'd0);
      write_byte(8'h02, a); chk("rd_ptr_ack", 32'(a), 32'd0);
      bus_start();
      write_byte(8'hD1, a); chk("rd_raddr_ack", 32'(a), 32'd0);
      read_byte(1'b0, d); chk("rd_byte0", 32'(d), 32'h3C);
      read_byte(1'b1, d); chk("rd_byte1", 32'(d), 32'hAA);
      chk("rd_sda_released", 32'(sda_out), 32'd1);
      chk("rd_busy_after_nack", 32'(busy), 32'd0);
      bus_stop();

      // address mismatch: bus ignored, SDA never pulled
      lo0 = lo_cnt; hw0 = hw_cnt;
      bus_start();
      write_byte(8'hA0, a); chk("mm_addr_nack", 32'(a), 32'd1);
      chk("mm_busy", 32'(busy), 32'd0);
      write_byte(8'h00, a); chk("mm_data_nack", 32'(a), 32'd1);
      bus_stop();
      chk("mm_sda_never_low", 32'(lo_cnt - lo0), 32'd0);
      chk("mm_no_hw", 32'(hw_cnt - hw0), 32'd0);
      rd_reg(4'd3, d); chk("mm_reg3_kept", 32'(d), 32'hAA);

      // pointer wrap 0x0F -> 0x10 lands on reg 0
      bus_start();
      write_byte(8'hD0, a); write_byte(8'h0F, a);
      write_byte(8'h11, a); write_byte(8'h22, a);
      chk("wrap_last_ack", 32'(a), 32'd0);
      bus_stop();
      rd_reg(4'd15, d); chk("wrap_reg15", 32'(d), 32'h11);
      rd_reg(4'd0, d);  chk("wrap_reg0", 32'(d), 32'h22);

      // same-cycle collision: fabric write holds until the host write strobe
      hw0 = hw_cnt;
      bus_start();
      write_byte(8'hD0, a); write_byte(8'h07, a);
      loc_we = 1'b1; loc_addr = 4'd7; loc_wdata = 8'h77;
      fork
         write_byte(8'h11, a);
         begin : watch
            int n;
            n = 0;
            while (host_wr !== 1'b1 && n < 2000) begin
               @(negedge clk);
               n++;
            end
            loc_we = 1'b0;
            chk("col_strobe_seen", 32'(host_wr), 32'd1);
         end
      join
      bus_stop();
      rd_reg(4'd7, d); chk("col_reg7_loc_wins", 32'(d), 32'h77);
      chk("col_hw_pulse", 32'(hw_cnt - hw0), 32'd1);
      chk("col_hw_data", {20'd0, hw_addr, hw_data}, {20'd0, 4'd7, 8'h11});

      // reset while the target drives a 0 bit in RDATA
      bus_start();
      write_byte(8'hD0, a); write_byte(8'h06, a);
      bus_start();
      write_byte(8'hD1, a); chk("rst_mid_raddr_ack", 32'(a), 32'd0);
      chk("rst_mid_sda_low_before", 32'(sda_out), 32'd0);
      reset_n = 1'b0;
      tick(1);
      chk("rst_mid_sda_released", 32'(sda_out), 32'd1);
      chk("rst_mid_state", 32'(dut.state), 32'(IDLE));
      chk("rst_mid_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      lo0 = lo_cnt;
      for (int i = 0; i < 9; i++) clk_bit(1'b1, a);
      chk("rst_mid_bus_ignored", 32'(lo_cnt - lo0), 32'd0);
      bus_stop();

      // pointer 0x75: WHOAMI when enabled, otherwise alias of reg 5
      loc_write(4'd5, 8'h5A);
      hw0 = hw_cnt;
      bus_start();
      write_byte(8'hD0, a); write_byte(8'h75, a);
      write_byte(8'h99, a); chk("who_wr_ack", 32'(a), 32'd0);
      bus_stop();
      bus_start();
      write_byte(8'hD0, a); write_byte(8'h75, a);
      bus_start();
      write_byte(8'hD1, a);
      read_byte(1'b1, d);
      bus_stop();
`ifdef I2C_TARGET_WHOAMI_EN
      chk("who_hw", 32'(hw_cnt - hw0), 32'd0);
      chk("who_rd", 32'(d), 32'h68);
      rd_reg(4'd5, d); chk("who_reg5", 32'(d), 32'h5A);
`else
      chk("who_hw", 32'(hw_cnt - hw0), 32'd1);
      chk("who_rd", 32'(d), 32'h99);
      rd_reg(4'd5, d); chk("who_reg5", 32'(d), 32'h99);
`endif

      chk("hw_one_cycle", 32'(hw_wide), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
